// File: rtl/fifo_wr_ctrl.sv
// Two-entry skid buffer between a valid/ready source and a FIFO write port.
// Optional statistics counters are built when FIFO_WR_STATS_EN is defined.
module fifo_wr_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  wr_clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    input  logic                  fifo_full,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_din,
    output logic                  busy,
    output logic [15:0]           byte_count,
    output logic [15:0]           stall_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                  state_reg;
    logic [DATA_WIDTH-1:0]   main_reg;
    logic [DATA_WIDTH-1:0]   skid_reg;
    logic                    s_ready_reg;
    logic                    xfer;
    logic                    wr;

    assign xfer       = s_valid & s_ready_reg;
    assign wr         = (state_reg != EMPTY) & ~fifo_full;
    assign fifo_wr_en = wr;
    assign fifo_din   = main_reg;
    assign s_ready    = s_ready_reg;
    assign busy       = (state_reg != EMPTY);

    // s_ready is kept as a flop that tracks "next state is not TWO".
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            state_reg   <= EMPTY;
            main_reg    <= '0;
            skid_reg    <= '0;
            s_ready_reg <= 1'b1;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (xfer) begin
                        main_reg  <= s_data;
                        state_reg <= ONE;
                    end
                end
                ONE: begin
                    if (wr && xfer) begin
                        main_reg <= s_data;
                    end else if (wr) begin
                        state_reg <= EMPTY;
                    end else if (xfer) begin
                        skid_reg    <= s_data;
                        state_reg   <= TWO;
                        s_ready_reg <= 1'b0;
                    end
                end
                TWO: begin
                    if (wr) begin
                        main_reg    <= skid_reg;
                        state_reg   <= ONE;
                        s_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg   <= EMPTY;
                    s_ready_reg <= 1'b1;
                end
            endcase
        end
    end

`ifdef FIFO_WR_STATS_EN
    logic [15:0] byte_count_reg;
    logic [15:0] stall_count_reg;

    // Both counters wrap naturally at 16 bits.
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            byte_count_reg  <= '0;
            stall_count_reg <= '0;
        end else begin
            if (xfer) begin
                byte_count_reg <= byte_count_reg + 16'd1;
            end
            if ((state_reg != EMPTY) && fifo_full) begin
                stall_count_reg <= stall_count_reg + 16'd1;
            end
        end
    end

    assign byte_count  = byte_count_reg;
    assign stall_count = stall_count_reg;
`else
    assign byte_count  = '0;
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed and random checks for the fifo_wr_ctrl skid buffer.
module tb_fifo_wr_ctrl;

    logic        wr_clk = 1'b0;
    logic        rst = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_ready;
    logic        fifo_full = 1'b0;
    logic        fifo_wr_en;
    logic [7:0]  fifo_din;
    logic        busy;
    logic [15:0] byte_count;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;

    fifo_wr_ctrl #(.DATA_WIDTH(8)) dut (
        .wr_clk      (wr_clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .fifo_full   (fifo_full),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_din    (fifo_din),
        .busy        (busy),
        .byte_count  (byte_count),
        .stall_count (stall_count)
    );

    always #5 wr_clk = ~wr_clk;

    task automatic step();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic do_reset();
        s_valid   = 1'b0;
        s_data    = 8'h00;
        fifo_full = 1'b0;
        #1 rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b exp 1", s_ready); end
        checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b exp 0", fifo_wr_en); end
        checks++; if (fifo_din !== 8'h00) begin errors++; $display("FAIL reset_din got %h exp 00", fifo_din); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (byte_count !== 16'd0) begin errors++; $display("FAIL reset_byte_count got %0d exp 0", byte_count); end
        checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL reset_stall_count got %0d exp 0", stall_count); end
        // A valid word presented during reset must not be captured.
        s_valid = 1'b1;
        s_data  = 8'hFF;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_hold_busy got %b exp 0", busy); end
        s_valid = 1'b0;
        rst = 1'b0;
        $display("reset: s_ready=%b busy=%b", s_ready, busy);
    endtask

    task automatic test_single();
        do_reset();
        s_valid = 1'b1;
        s_data  = 8'hA5;
        step();
        s_valid = 1'b0;
        s_data  = 8'h3C;
        checks++; if (fifo_wr_en !== 1'b1) begin errors++; $display("FAIL single_wr_en got %b exp 1", fifo_wr_en); end
        checks++; if (fifo_din !== 8'hA5) begin errors++; $display("FAIL single_din got %h exp a5", fifo_din); end
        $display("single: write %h", fifo_din);
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after got %b exp 0", busy); end
        checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL single_wr_en_after got %b exp 0", fifo_wr_en); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(i);
            step();
            checks++; if (fifo_wr_en !== 1'b1 || fifo_din !== 8'(i)) begin
                errors++; $display("FAIL stream_word%0d got en=%b din=%h exp en=1 din=%h", i, fifo_wr_en, fifo_din, 8'(i));
            end
            checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL stream_ready%0d got %b exp 1", i, s_ready); end
            $display("stream: write %h", fifo_din);
        end
        s_valid = 1'b0;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stream_busy_end got %b exp 0", busy); end
`ifdef FIFO_WR_STATS_EN
        checks++; if (byte_count !== 16'd16) begin errors++; $display("FAIL stream_byte_count got %0d exp 16", byte_count); end
`else
        checks++; if (byte_count !== 16'd0) begin errors++; $display("FAIL stream_byte_count got %0d exp 0", byte_count); end
`endif
    endtask

    task automatic test_full_backpressure();
        do_reset();
        fifo_full = 1'b1;
        s_valid   = 1'b1;
        s_data    = 8'h11;
        step();
        checks++; if (s_ready !== 1'b1 || fifo_wr_en !== 1'b0) begin
            errors++; $display("FAIL full_one got ready=%b en=%b exp ready=1 en=0", s_ready, fifo_wr_en);
        end
        s_data = 8'h22;
        step();
        s_data = 8'h33;
        checks++; if (s_ready !== 1'b0 || fifo_wr_en !== 1'b0 || fifo_din !== 8'h11) begin
            errors++; $display("FAIL full_two got ready=%b en=%b din=%h exp ready=0 en=0 din=11", s_ready, fifo_wr_en, fifo_din);
        end
        step();
        checks++; if (s_ready !== 1'b0 || fifo_wr_en !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL full_hold got ready=%b en=%b busy=%b exp ready=0 en=0 busy=1", s_ready, fifo_wr_en, busy);
        end
        fifo_full = 1'b0;
        #1;
        checks++; if (fifo_wr_en !== 1'b1 || fifo_din !== 8'h11) begin
            errors++; $display("FAIL full_rel1 got en=%b din=%h exp en=1 din=11", fifo_wr_en, fifo_din);
        end
        $display("full: write %h", fifo_din);
        step();
        checks++; if (fifo_wr_en !== 1'b1 || fifo_din !== 8'h22 || s_ready !== 1'b1) begin
            errors++; $display("FAIL full_rel2 got en=%b din=%h ready=%b exp en=1 din=22 ready=1", fifo_wr_en, fifo_din, s_ready);
        end
        $display("full: write %h", fifo_din);
        step();
        s_valid = 1'b0;
        checks++; if (fifo_wr_en !== 1'b1 || fifo_din !== 8'h33) begin
            errors++; $display("FAIL full_rel3 got en=%b din=%h exp en=1 din=33", fifo_wr_en, fifo_din);
        end
        $display("full: write %h", fifo_din);
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_end got %b exp 0", busy); end
    endtask

    task automatic test_stall();
        do_reset();
        fifo_full = 1'b1;
        s_valid   = 1'b1;
        s_data    = 8'h5A;
        step();
        s_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL stall_en%0d got %b exp 0", i, fifo_wr_en); end
        end
`ifdef FIFO_WR_STATS_EN
        checks++; if (stall_count !== 16'd5) begin errors++; $display("FAIL stall_count got %0d exp 5", stall_count); end
`else
        checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL stall_count got %0d exp 0", stall_count); end
`endif
        fifo_full = 1'b0;
        #1;
        checks++; if (fifo_wr_en !== 1'b1 || fifo_din !== 8'h5A) begin
            errors++; $display("FAIL stall_release got en=%b din=%h exp en=1 din=5a", fifo_wr_en, fifo_din);
        end
        $display("stall: write %h after stall_count=%0d", fifo_din, stall_count);
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        fifo_full = 1'b1;
        s_valid   = 1'b1;
        s_data    = 8'hAA;
        step();
        s_data = 8'hBB;
        step();
        s_valid = 1'b0;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL mid_two_ready got %b exp 0", s_ready); end
        #2 rst = 1'b1;
        fifo_full = 1'b0;
        #1;
        checks++; if (s_ready !== 1'b1 || busy !== 1'b0 || fifo_wr_en !== 1'b0 || fifo_din !== 8'h00) begin
            errors++; $display("FAIL mid_async got ready=%b busy=%b en=%b din=%h exp ready=1 busy=0 en=0 din=00", s_ready, busy, fifo_wr_en, fifo_din);
        end
        step();
        rst     = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h77;
        step();
        s_valid = 1'b0;
        checks++; if (fifo_wr_en !== 1'b1 || fifo_din !== 8'h77) begin
            errors++; $display("FAIL mid_first_after got en=%b din=%h exp en=1 din=77", fifo_wr_en, fifo_din);
        end
        $display("reset_mid: write %h", fifo_din);
        step();
        checks++; if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin
            errors++; $display("FAIL mid_drain got busy=%b en=%b exp busy=0 en=0", busy, fifo_wr_en);
        end
    endtask

    task automatic test_random();
        logic [7:0]  sb[$];
        logic [7:0]  exp_word;
        logic [15:0] exp_bytes;
        do_reset();
        exp_bytes = '0;
        for (int n = 0; n < 10000 + 4; n++) begin
            if (n < 10000) begin
                s_valid   = 1'($urandom_range(0, 1));
                s_data    = 8'($urandom);
                fifo_full = ($urandom_range(0, 3) == 0);
            end else begin
                s_valid   = 1'b0;
                fifo_full = 1'b0;
            end
            #1;
            if (s_valid && s_ready) begin
                sb.push_back(s_data);
                exp_bytes = exp_bytes + 16'd1;
            end
            if (fifo_wr_en) begin
                checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL rand_write_while_full cycle %0d got en=1 exp en=0", n); end
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rand_extra_write cycle %0d got %h exp none", n, fifo_din);
                end else begin
                    exp_word = sb.pop_front();
                    checks++; if (fifo_din !== exp_word) begin
                        errors++; $display("FAIL rand_order cycle %0d got %h exp %h", n, fifo_din, exp_word);
                    end
                    $display("random: write %h", fifo_din);
                end
            end
            @(posedge wr_clk);
            #1;
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL rand_lost_words got %0d exp 0", sb.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand_busy_end got %b exp 0", busy); end
`ifdef FIFO_WR_STATS_EN
        checks++; if (byte_count !== exp_bytes) begin errors++; $display("FAIL rand_byte_count got %0d exp %0d", byte_count, exp_bytes); end
`else
        checks++; if (byte_count !== 16'd0) begin errors++; $display("FAIL rand_byte_count got %0d exp 0", byte_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full_backpressure();
        test_stall();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
